// File: rtl/alu_seq_ctrl_if.sv
// Byte-stream input and result handshake bundle for alu_seq_ctrl.
// master = upstream/downstream side, slave = the sequencer itself.
interface alu_seq_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [1:0]  in_op;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic [1:0]  res_op;

    modport master (
        output in_valid, in_data, in_op, res_ready,
        input  in_ready, res_valid, res_data, res_op
    );

    modport slave (
        input  in_valid, in_data, in_op, res_ready,
        output in_ready, res_valid, res_data, res_op
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Sequences three operand bytes onto an external ALU, waits SETTLE_CYCLES edges, captures the result.
// Optional feature macro: ALU_SEQ_CNT_EN adds an 8-bit wrapping count of completed result handshakes.
module alu_seq_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic           clk,
    input  logic           reset,
    alu_seq_ctrl_if.slave  bus,
    output logic [7:0]     A,
    output logic [7:0]     B,
    output logic [7:0]     C,
    output logic           S0,
    output logic           S1,
    input  logic [15:0]    alu_out
`ifdef ALU_SEQ_CNT_EN
    ,
    output logic [7:0]     res_count
`endif
);

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_B = 3'd1,
        LOAD_C = 3'd2,
        SETTLE = 3'd3,
        HOLD   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  a_q, a_d, b_q, b_d, c_q, c_d;
    logic [1:0]  sel_q, sel_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        in_ready_q, in_ready_d;
    logic        res_valid_q, res_valid_d;
    logic [15:0] res_data_q, res_data_d;
    logic [1:0]  res_op_q, res_op_d;
    logic        accept_s;
    logic        res_hs_s;

    // Next-state and datapath updates; in_ready is registered from the next state.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_op_d    = res_op_q;
        accept_s    = bus.in_valid && in_ready_q;
        res_hs_s    = res_valid_q && bus.res_ready;

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    a_d     = bus.in_data;
                    sel_d   = bus.in_op;
                    state_d = LOAD_B;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD_B: begin
                if (accept_s) begin
                    b_d     = bus.in_data;
                    state_d = LOAD_C;
                end else begin
                    state_d = LOAD_B;
                end
            end
            LOAD_C: begin
                if (accept_s) begin
                    c_d     = bus.in_data;
                    cnt_d   = SETTLE_INIT;
                    state_d = SETTLE;
                end else begin
                    state_d = LOAD_C;
                end
            end
            SETTLE: begin
                // The edge that sees a count of one is the last settle edge and captures.
                if (cnt_q == 4'd1) begin
                    res_data_d  = alu_out;
                    res_op_d    = sel_q;
                    res_valid_d = 1'b1;
                    cnt_d       = 4'd0;
                    state_d     = HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                if (res_hs_s) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d = (state_d == IDLE) || (state_d == LOAD_B) || (state_d == LOAD_C);
    end

    // State and datapath registers; reset lands in IDLE ready to take an A byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            a_q         <= 8'd0;
            b_q         <= 8'd0;
            c_q         <= 8'd0;
            sel_q       <= 2'd0;
            cnt_q       <= 4'd0;
            in_ready_q  <= 1'b1;
            res_valid_q <= 1'b0;
            res_data_q  <= 16'd0;
            res_op_q    <= 2'd0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_op_q    <= res_op_d;
        end
    end

`ifdef ALU_SEQ_CNT_EN
    logic [7:0] res_count_q, res_count_d;

    // Completed-result counter, wraps naturally at 8 bits.
    always_comb begin
        if (res_hs_s) begin
            res_count_d = res_count_q + 8'd1;
        end else begin
            res_count_d = res_count_q;
        end
    end

    // Result counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_count_q <= 8'd0;
        end else begin
            res_count_q <= res_count_d;
        end
    end

    assign res_count = res_count_q;
`endif

    assign A             = a_q;
    assign B             = b_q;
    assign C             = c_q;
    assign S0            = sel_q[1];
    assign S1            = sel_q[0];
    assign bus.in_ready  = in_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_op    = res_op_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: one instance with SETTLE_CYCLES=1, one with 4.
// Define ALU_SEQ_CNT_EN to also exercise the result counter.
module tb_alu_seq_ctrl;

    logic        clk;
    logic        reset;
    logic [7:0]  a1, b1, c1, a4, b4, c4;
    logic        s0_1, s1_1, s0_4, s1_4;
    logic [15:0] alu1, alu4;
`ifdef ALU_SEQ_CNT_EN
    logic [7:0]  rc1, rc4;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    alu_seq_ctrl_if if1();
    alu_seq_ctrl_if if4();

    alu_seq_ctrl #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .reset(reset), .bus(if1),
        .A(a1), .B(b1), .C(c1), .S0(s0_1), .S1(s1_1), .alu_out(alu1)
`ifdef ALU_SEQ_CNT_EN
        , .res_count(rc1)
`endif
    );

    alu_seq_ctrl #(.SETTLE_CYCLES(4)) u_dut4 (
        .clk(clk), .reset(reset), .bus(if4),
        .A(a4), .B(b4), .C(c4), .S0(s0_4), .S1(s1_4), .alu_out(alu4)
`ifdef ALU_SEQ_CNT_EN
        , .res_count(rc4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send1(input logic [7:0] d, input logic [1:0] op);
        if1.in_valid = 1'b1;
        if1.in_data  = d;
        if1.in_op    = op;
        step();
        if1.in_valid = 1'b0;
    endtask

    task automatic send4(input logic [7:0] d, input logic [1:0] op);
        if4.in_valid = 1'b1;
        if4.in_data  = d;
        if4.in_op    = op;
        step();
        if4.in_valid = 1'b0;
    endtask

    task automatic pkt1(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        send1(a, 2'b00);
        send1(b, 2'b00);
        send1(c, 2'b00);
        step();
        if1.res_ready = 1'b1;
        step();
        if1.res_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        if1.in_valid = 1'b0; if1.in_data = 8'd0; if1.in_op = 2'b00; if1.res_ready = 1'b0;
        if4.in_valid = 1'b0; if4.in_data = 8'd0; if4.in_op = 2'b00; if4.res_ready = 1'b0;
        alu1 = 16'd0;
        alu4 = 16'd0;

        // Asynchronous reset: raised between clock edges, observed before any edge.
        #2 reset = 1'b1;
        #1;
        check("rst_A", {24'd0, a1}, 32'd0);
        check("rst_sel", {30'd0, s0_1, s1_1}, 32'd0);
        check("rst_res_valid", {31'd0, if1.res_valid}, 32'd0);
        check("rst_res_data", {16'd0, if1.res_data}, 32'd0);
        check("rst_in_ready", {31'd0, if1.in_ready}, 32'd1);
        step();
        step();
        reset = 1'b0;

        // Back-to-back packet 100, 20, 34 with op 00.
        alu1 = 16'd154;
        send1(8'd100, 2'b00);
        check("t1_A", {24'd0, a1}, 32'd100);
        send1(8'd20, 2'b00);
        check("t1_B", {24'd0, b1}, 32'd20);
        send1(8'd34, 2'b00);
        check("t1_C", {24'd0, c1}, 32'd34);
        check("t1_sel", {30'd0, s0_1, s1_1}, 32'd0);
        check("t1_valid_early", {31'd0, if1.res_valid}, 32'd0);
        check("t1_ready_settle", {31'd0, if1.in_ready}, 32'd0);
        step();
        check("t1_valid", {31'd0, if1.res_valid}, 32'd1);
        check("t1_data", {16'd0, if1.res_data}, 32'd154);
        check("t1_op", {30'd0, if1.res_op}, 32'd0);
        if1.res_ready = 1'b1;
        step();
        check("t1_hs_valid", {31'd0, if1.res_valid}, 32'd0);
        check("t1_hs_ready", {31'd0, if1.in_ready}, 32'd1);
        check("t1_data_kept", {16'd0, if1.res_data}, 32'd154);
        step();
        check("t1_idle_rr_valid", {31'd0, if1.res_valid}, 32'd0);
        check("t1_idle_rr_ready", {31'd0, if1.in_ready}, 32'd1);
        if1.res_ready = 1'b0;

        // Op 01 with three idle cycles between bytes; in_data toggles while invalid.
        alu1 = 16'd1530;
        send1(8'd15, 2'b01);
        check("t2_A", {24'd0, a1}, 32'd15);
        check("t2_sel", {30'd0, s0_1, s1_1}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            if1.in_data = 8'hEE;
            if1.in_op   = 2'b11;
            step();
            check("t2_gap1_B", {24'd0, b1}, 32'd20);
            check("t2_gap1_ready", {31'd0, if1.in_ready}, 32'd1);
        end
        send1(8'd34, 2'b11);
        check("t2_B", {24'd0, b1}, 32'd34);
        check("t2_sel_kept", {30'd0, s0_1, s1_1}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            if1.in_data = 8'hDD;
            step();
            check("t2_gap2_C", {24'd0, c1}, 32'd34);
        end
        send1(8'd3, 2'b00);
        check("t2_C", {24'd0, c1}, 32'd3);
        check("t2_valid_early", {31'd0, if1.res_valid}, 32'd0);
        step();
        check("t2_valid", {31'd0, if1.res_valid}, 32'd1);
        check("t2_data", {16'd0, if1.res_data}, 32'd1530);
        check("t2_op", {30'd0, if1.res_op}, 32'd1);

        // Hold with res_ready low while upstream keeps offering a byte.
        if1.in_valid = 1'b1;
        if1.in_data  = 8'd77;
        if1.in_op    = 2'b01;
        alu1 = 16'hFFFF;
        for (int i = 0; i < 10; i++) begin
            step();
            check("t3_hold_ready", {31'd0, if1.in_ready}, 32'd0);
            check("t3_hold_data", {16'd0, if1.res_data}, 32'd1530);
            check("t3_hold_A", {24'd0, a1}, 32'd15);
        end
        if1.res_ready = 1'b1;
        step();
        if1.res_ready = 1'b0;
        check("t3_hs_valid", {31'd0, if1.res_valid}, 32'd0);
        check("t3_hs_A_not_yet", {24'd0, a1}, 32'd15);
        step();
        if1.in_valid = 1'b0;
        check("t3_next_A", {24'd0, a1}, 32'd77);

        // Settle of four edges with alu_out changing mid-settle.
        alu4 = 16'h0000;
        send4(8'd1, 2'b11);
        send4(8'd2, 2'b11);
        send4(8'd3, 2'b11);
        for (int k = 1; k <= 4; k++) begin
            step();
            check("t4_valid_timing", {31'd0, if4.res_valid}, (k == 4) ? 32'd1 : 32'd0);
            if (k == 2) begin
                alu4 = 16'h1234;
            end
        end
        check("t4_data", {16'd0, if4.res_data}, 32'h1234);
        check("t4_op", {30'd0, if4.res_op}, 32'd3);
        if4.res_ready = 1'b1;
        step();
        if4.res_ready = 1'b0;
        check("t4_hs_valid", {31'd0, if4.res_valid}, 32'd0);

        // Reset after an A byte (dut1 currently holds A=77 in LOAD_B).
        reset = 1'b1;
        #1;
        check("t5_rst_A", {24'd0, a1}, 32'd0);
        check("t5_rst_sel", {30'd0, s0_1, s1_1}, 32'd0);
        check("t5_rst_data", {16'd0, if1.res_data}, 32'd0);
        check("t5_rst_ready", {31'd0, if1.in_ready}, 32'd1);
        step();
        reset = 1'b0;
        alu1 = 16'hBEEF;
        send1(8'd1, 2'b10);
        check("t5_A_after_rst", {24'd0, a1}, 32'd1);
        check("t5_B_cleared", {24'd0, b1}, 32'd0);
        check("t5_sel", {30'd0, s0_1, s1_1}, 32'd2);
        send1(8'd2, 2'b00);
        send1(8'd3, 2'b00);
        step();
        check("t5_valid", {31'd0, if1.res_valid}, 32'd1);
        check("t5_data", {16'd0, if1.res_data}, 32'hBEEF);
        check("t5_op", {30'd0, if1.res_op}, 32'd2);

        // Reset during HOLD discards the pending result.
        reset = 1'b1;
        #1;
        check("t6_rst_valid", {31'd0, if1.res_valid}, 32'd0);
        check("t6_rst_data", {16'd0, if1.res_data}, 32'd0);
        check("t6_rst_op", {30'd0, if1.res_op}, 32'd0);
        check("t6_rst_C", {24'd0, c1}, 32'd0);
        check("t6_rst_ready", {31'd0, if1.in_ready}, 32'd1);
        step();
        reset = 1'b0;
        send1(8'd9, 2'b00);
        check("t6_A_after_rst", {24'd0, a1}, 32'd9);

`ifdef ALU_SEQ_CNT_EN
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t7_cnt_rst", {24'd0, rc1}, 32'd0);
        alu1 = 16'd5;
        pkt1(8'd1, 8'd2, 8'd3);
        check("t7_cnt_one", {24'd0, rc1}, 32'd1);
        for (int i = 1; i < 257; i++) begin
            pkt1(8'(i), 8'd2, 8'd3);
        end
        check("t7_cnt_wrap", {24'd0, rc1}, 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
